// File: rtl/priority_resolver.sv
// priority_resolver: IR sync/IRR capture, masking, fixed/rotating priority resolution and INTA sequencing
module priority_resolver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] interrupt_request,
  input  logic       level_or_edge_triggered,
  input  logic [7:0] interrupt_mask,
  input  logic       special_mask_mode,
  input  logic [7:0] in_service_register,
  input  logic       priority_rotate,
  input  logic [2:0] priority_rotate_level,
  input  logic       interrupt_acknowledge_n,
  output logic       interrupt,
  output logic [7:0] highest_priority_interrupt,
  output logic       acknowledge,
  output logic       end_of_acknowledge,
  output logic [2:0] lowest_priority
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACK1 = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] ACK2 = 2'd3;

  logic [SYNC_STAGES*8-1:0] sync_q;
  logic [7:0] ir_sync, ir_prev, irr, pend, rot_pend, rot_isr, allow, eff, candidate, clr;
  logic [2:0] base;
  logic [1:0] state;
  logic       inta_q, inta_fall, inta_rise;

  function automatic logic [7:0] rotr(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} >> n;
    return d[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  assign ir_sync   = sync_q[SYNC_STAGES*8-1 -: 8];
  assign inta_fall = inta_q & ~interrupt_acknowledge_n;
  assign inta_rise = ~inta_q & interrupt_acknowledge_n;
  assign base      = lowest_priority + 3'd1;

  always_comb begin
    pend      = irr & ~interrupt_mask & (special_mask_mode ? ~in_service_register : 8'hff);
    rot_pend  = rotr(pend, base);
    rot_isr   = rotr(in_service_register, base);
    allow     = (special_mask_mode || rot_isr == 8'd0) ? 8'hff : (rot_isr & (~rot_isr + 8'd1)) - 8'd1;
    eff       = rot_pend & allow;
    candidate = rotl(eff & (~eff + 8'd1), base);
    clr       = (state == IDLE && inta_fall && !level_or_edge_triggered) ? candidate : 8'd0;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_q  <= '0;
      ir_prev <= '0;
      irr     <= '0;
      inta_q  <= 1'b1;
    end else begin
      sync_q  <= (SYNC_STAGES*8)'({sync_q, interrupt_request});
      ir_prev <= ir_sync;
      irr     <= level_or_edge_triggered ? ir_sync : (irr & ~clr) | (ir_sync & ~ir_prev);
      inta_q  <= interrupt_acknowledge_n;
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) lowest_priority <= 3'd7;
    else if (priority_rotate) lowest_priority <= priority_rotate_level;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state                      <= IDLE;
      interrupt                  <= 1'b0;
      highest_priority_interrupt <= '0;
      acknowledge                <= 1'b0;
      end_of_acknowledge         <= 1'b0;
    end else begin
      acknowledge        <= 1'b0;
      end_of_acknowledge <= 1'b0;
      case (state)
        IDLE: begin
          interrupt                  <= (candidate != 8'd0) && !inta_fall;
          highest_priority_interrupt <= candidate;
          if (inta_fall) begin
            acknowledge <= 1'b1;
            state       <= ACK1;
          end
        end
        ACK1: if (inta_rise) state <= GAP;
        GAP:  if (inta_fall) state <= ACK2;
        default: if (inta_rise) begin
          end_of_acknowledge <= 1'b1;
          state              <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_priority_resolver.sv
// tb_priority_resolver: directed plus random checks of priority_resolver against a behavioural model
module tb_priority_resolver;
  localparam int S = 2;
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] ir = '0, imr = '0, isr = '0;
  logic       lvl = 1'b0, smm = 1'b0, rot = 1'b0, inta_n = 1'b1;
  logic [2:0] rot_lvl = '0;
  logic       intr, ack, eoa;
  logic [7:0] hpi;
  logic [2:0] lp;
  int errors = 0, checks = 0;
  logic [7:0] hist [S+1];
  logic [7:0] m_irr, m_hpi;
  logic [2:0] m_lp;
  int         m_phase;
  logic       m_int, m_ack, m_eoa, m_inta_q;

  priority_resolver #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .interrupt_request(ir), .level_or_edge_triggered(lvl),
    .interrupt_mask(imr), .special_mask_mode(smm), .in_service_register(isr),
    .priority_rotate(rot), .priority_rotate_level(rot_lvl), .interrupt_acknowledge_n(inta_n),
    .interrupt(intr), .highest_priority_interrupt(hpi), .acknowledge(ack),
    .end_of_acknowledge(eoa), .lowest_priority(lp)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_cand(input logic [7:0] req, msk, svc, input logic sm, input logic [2:0] bottom);
    int l;
    for (int k = 1; k <= 8; k++) begin
      l = (int'(bottom) + k) % 8;
      if (!sm && svc[l]) return 8'd0;
      if (req[l] && !msk[l] && !(sm && svc[l])) return 8'd1 << l;
    end
    return 8'd0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("interrupt", {7'd0, intr}, {7'd0, m_int});
    chk("highest_priority_interrupt", hpi, m_hpi);
    chk("acknowledge", {7'd0, ack}, {7'd0, m_ack});
    chk("end_of_acknowledge", {7'd0, eoa}, {7'd0, m_eoa});
    chk("lowest_priority", {5'd0, lp}, {5'd0, m_lp});
  endtask

  task automatic m_reset();
    for (int i = 0; i <= S; i++) hist[i] = '0;
    m_irr = '0; m_hpi = '0; m_lp = 3'd7; m_phase = 0;
    m_int = 1'b0; m_ack = 1'b0; m_eoa = 1'b0; m_inta_q = 1'b1;
  endtask

  task automatic tick();
    logic [7:0] c, sy, pv, clr;
    logic fall, rise;
    sy = hist[S-1];
    pv = hist[S];
    c = ref_cand(m_irr, imr, isr, smm, m_lp);
    fall = m_inta_q && !inta_n;
    rise = !m_inta_q && inta_n;
    clr = (m_phase == 0 && fall && !lvl) ? c : 8'd0;
    m_irr = lvl ? sy : ((m_irr & ~clr) | (sy & ~pv));
    m_ack = 1'b0;
    m_eoa = 1'b0;
    if (m_phase == 0) begin
      m_int = (c != 0) && !fall;
      m_hpi = c;
      if (fall) begin m_ack = 1'b1; m_phase = 1; end
    end else if (m_phase == 1 && rise) m_phase = 2;
    else if (m_phase == 2 && fall) m_phase = 3;
    else if (m_phase == 3 && rise) begin m_eoa = 1'b1; m_phase = 0; end
    if (rot) m_lp = rot_lvl;
    for (int i = S; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ir;
    m_inta_q = inta_n;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ir = '0; imr = '0; isr = '0; lvl = 1'b0; smm = 1'b0; rot = 1'b0; rot_lvl = '0; inta_n = 1'b1;
    #1;
    m_reset();
    check_all();
    chk("reset_lowest_priority", {5'd0, lp}, 8'd7);
    chk("reset_interrupt", {7'd0, intr}, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic inta_rest();
    inta_n = 1'b1; tick(); tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    chk("eoa_pulse", {7'd0, eoa}, 8'd1);
  endtask

  task automatic inta_pair();
    inta_n = 1'b0; tick();
    chk("ack_pulse", {7'd0, ack}, 8'd1);
    chk("int_drop", {7'd0, intr}, 8'd0);
    inta_rest();
  endtask

  initial begin
    #2;
    do_reset();
    ticks(2);
    ir = 8'h20; ticks(3);
    chk("ir5_latency_early", {7'd0, intr}, 8'd0);
    tick();
    chk("ir5_int", {7'd0, intr}, 8'd1);
    chk("ir5_hpi", hpi, 8'h20);
    inta_pair();
    ticks(3);
    chk("ir5_cleared", {7'd0, intr}, 8'd0);
    ir = 8'h00; ticks(2);
    ir = 8'h44; ticks(4);
    chk("ir2_beats_ir6", hpi, 8'h04);
    imr = 8'h04; tick();
    chk("mask_ir2", hpi, 8'h40);
    do_reset();
    isr = 8'h08; ir = 8'h20; ticks(4);
    chk("isr3_blocks_ir5", {7'd0, intr}, 8'd0);
    smm = 1'b1; tick();
    chk("smm_int", {7'd0, intr}, 8'd1);
    chk("smm_hpi", hpi, 8'h20);
    smm = 1'b0; ir = 8'h22; ticks(4);
    chk("ir1_over_isr3", hpi, 8'h02);
    do_reset();
    rot = 1'b1; rot_lvl = 3'd4; tick();
    rot = 1'b0;
    chk("rotate_lp4", {5'd0, lp}, 8'd4);
    ir = 8'h28; ticks(4);
    chk("rotated_winner", hpi, 8'h20);
    rot = 1'b1; rot_lvl = 3'd0; inta_n = 1'b0; tick();
    rot = 1'b0;
    chk("rot_inta_ack", {7'd0, ack}, 8'd1);
    chk("rot_inta_old_order", hpi, 8'h20);
    chk("rot_inta_lp0", {5'd0, lp}, 8'd0);
    inta_rest();
    ticks(2);
    chk("after_rot_ir3", hpi, 8'h08);
    do_reset();
    lvl = 1'b1; ir = 8'h01; ticks(4);
    chk("level_int", {7'd0, intr}, 8'd1);
    inta_pair();
    tick();
    chk("level_reassert", {7'd0, intr}, 8'd1);
    ir = 8'h00; ticks(4);
    chk("level_idle", {7'd0, intr}, 8'd0);
    inta_n = 1'b0; tick();
    chk("spurious_ack", {7'd0, ack}, 8'd1);
    chk("spurious_hpi", hpi, 8'h00);
    inta_rest();
    do_reset();
    ir = 8'h10; ticks(4);
    inta_n = 1'b0; tick();
    inta_n = 1'b1; ticks(2);
    do_reset();
    chk("gap_reset_hpi", hpi, 8'h00);
    ticks(3);
    chk("gap_reset_no_eoa", {7'd0, eoa}, 8'd0);
    ir = 8'h10; ticks(4);
    chk("post_reset_int", {7'd0, intr}, 8'd1);
    chk("post_reset_hpi", hpi, 8'h10);
    inta_pair();
    for (int i = 0; i < 800; i++) begin
      if (i % 80 == 0) begin
        lvl = 1'($urandom_range(0, 1));
        smm = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) ir = 8'($urandom);
      if ($urandom_range(0, 7) == 0) imr = 8'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) isr = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom & $urandom & $urandom);
      rot = ($urandom_range(0, 9) == 0);
      rot_lvl = 3'($urandom);
      if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
